dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Sequential arbiter that shares the single data-memory port between the pipeline's memory stage (CPU) and a DMA/program-loader requester. It latches the winning request, issues exactly one memory access, waits out the fixed read latency and returns read data with a one-cycle done pulse. It drives `stallM` to the hazard unit while a CPU access is outstanding. It sits between the M-stage pipeline register and `datamemory`.

## Interface
- `DATA_WIDTH`, 32, data width.
- `ADDR_WIDTH`, 32, address width.
- `MEM_LATENCY`, 2, read latency of the memory in cycles (legal range 1..7).
- `STARVE_LIMIT`, 8, number of consecutive DMA arbitration losses before DMA is forced to win (guard builds only).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-low reset.
- `cpu_req` in 1: M-stage access request; held high until `cpu_done`.
- `cpu_we` in 1: 1 = store, 0 = load.
- `cpu_addr` in ADDR_WIDTH: CPU access address.
- `cpu_wdata` in DATA_WIDTH: CPU store data.
- `cpu_funct3` in 3: access size/sign, forwarded to memory.
- `cpu_rdata` out DATA_WIDTH: load data, valid while `cpu_done` is high.
- `cpu_done` out 1: one-cycle completion pulse.
- `stallM` out 1: `cpu_req & ~cpu_done`, to the hazard unit.
- `dma_req`, `dma_we` in 1: DMA request and write enable; same rules as the CPU.
- `dma_addr` in ADDR_WIDTH; `dma_wdata` in DATA_WIDTH: DMA address and write data.
- `dma_rdata` out DATA_WIDTH; `dma_done` out 1: DMA read data and completion pulse.
- `mem_en`, `mem_we` out 1: memory access strobe and write enable.
- `mem_addr` out ADDR_WIDTH; `mem_wdata` out DATA_WIDTH; `mem_funct3` out 3: memory access fields.
- `mem_rdata` in DATA_WIDTH: memory read data, valid `MEM_LATENCY` cycles after `mem_en`.

## Operation
- The FSM has four states: IDLE, ISSUE, WAIT, DONE.
- **IDLE**
  - If any request is high, pick a winner and latch its we/addr/wdata/funct3 and a grant id. Go to ISSUE.
  - DMA funct3 is always 3'b010 (word).
- **ISSUE**
  - `mem_en`=1 for exactly this cycle; all `mem_*` outputs are driven from registers.
  - Write: go to DONE. Read: load counter = `MEM_LATENCY`, go to WAIT.
- **WAIT**
  - Decrement the counter each cycle.
  - When the counter = 1: capture `mem_rdata` into the granted requester's rdata register and go to DONE.
- **DONE**
  - Pulse the granted requester's done for one cycle, then return to IDLE.
  - Requests are not sampled in DONE. A requester must drop `req` on the cycle after its done or it is re-arbitrated as a new access.
- **Arbitration:** CPU wins a simultaneous request by default. A request arriving while the block is busy waits; nothing is queued beyond the request line itself.
- **Registers:** `rdata` registers hold their value until the next read for the same requester. `mem_*` outputs are 0 when not in ISSUE.
- **Reset:** every output is 0 and the FSM goes to IDLE.
  - Reset mid-access abandons the access: no done pulse, and the counter and starvation count clear.

## Timing
- Request seen high in IDLE at cycle T: `mem_en` at T+1.
- Write: done at T+2.
- Read: `mem_rdata` is sampled at T+1+`MEM_LATENCY`; done and rdata appear at T+2+`MEM_LATENCY`.
- Minimum spacing between issues is 3 cycles (write) or `MEM_LATENCY`+3 cycles (read).
- `stallM` is combinational from `cpu_req` and the registered `cpu_done`. It falls in the done cycle, so the pipeline advances on that edge.

## Configuration
- `DMEM_ARB_STARVE_GUARD_EN` defined:
  - A starvation counter of width $clog2(`STARVE_LIMIT`+1) increments each time DMA requests in IDLE and loses. It saturates and clears when DMA is granted.
  - When the counter = `STARVE_LIMIT` and both request, DMA wins.
- Undefined: strict CPU priority, with no counter logic built (DMA may starve).

## Structure
- Package `dmem_arb_pkg`:
  - FSM state enum typedef.
  - Grant enum (GNT_CPU, GNT_DMA).
  - Constant DMA_FUNCT3 = 3'b010.
- One sub-module, `dmem_arb_starve_guard` (counter plus force-DMA output), instantiated only under the macro.

## Test plan
- CPU load, `MEM_LATENCY`=2: `cpu_req` at cycle 0, addr 0x10, memory returns 0xDEADBEEF → `mem_en` at cycle 1 and `cpu_done` with `cpu_rdata`=0xDEADBEEF at cycle 4. `stallM` is high in cycles 0–3 and low in cycle 4.
- DMA store at addr 0x40, data 0x12345678 → `mem_en`=`mem_we`=1, `mem_funct3`=3'b010 at cycle 1, and `dma_done` at cycle 2.
- CPU and DMA both request at cycle 0 → CPU is issued first. DMA is issued on the cycle after the next IDLE, and the two done pulses never overlap.
- Guard on, `STARVE_LIMIT`=2, both requesters reissue continuously → the grant order is CPU, CPU, DMA, CPU, CPU, DMA. With the guard off, DMA is never granted.
- `rst`=0 during WAIT of a CPU read → no `cpu_done`, all outputs 0 on the next cycle. After release, a new request issues normally with the full latency.
- Requester holding `req` one cycle past done → a second access is issued, which confirms the drop-after-done rule.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// ----------------------------------------------------------------------------
// dmem_arb_pkg : shared types and constants for the data-memory arbiter.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  typedef enum logic {
    GNT_CPU = 1'b0,
    GNT_DMA = 1'b1
  } grant_t;

  localparam logic [2:0] DMA_FUNCT3 = 3'b010;

endpackage

`default_nettype wire

// File: rtl/dmem_arb_starve_guard.sv
// ----------------------------------------------------------------------------
// dmem_arb_starve_guard : counts DMA arbitration losses, forces a DMA win at
// STARVE_LIMIT.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module dmem_arb_starve_guard #(
  parameter int STARVE_LIMIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic dma_lost,
  input  logic dma_granted,
  output logic force_dma
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] loss_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      loss_cnt <= '0;
    end else if (dma_granted) begin
      loss_cnt <= '0;
    end else if (dma_lost && (loss_cnt != CNT_W'(STARVE_LIMIT))) begin
      loss_cnt <= loss_cnt + 1'b1;
    end
  end

  assign force_dma = (loss_cnt == CNT_W'(STARVE_LIMIT));

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ----------------------------------------------------------------------------
// dmem_arbiter : shares the data-memory port between CPU M-stage and DMA.
// DMEM_ARB_STARVE_GUARD_EN adds the DMA starvation guard.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int MEM_LATENCY  = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  input  logic [2:0]            cpu_funct3,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_done,
  output logic                  stallM,
  input  logic                  dma_req,
  input  logic                  dma_we,
  input  logic [ADDR_WIDTH-1:0] dma_addr,
  input  logic [DATA_WIDTH-1:0] dma_wdata,
  output logic [DATA_WIDTH-1:0] dma_rdata,
  output logic                  dma_done,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [2:0]            mem_funct3,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  arb_state_t state;
  grant_t     gnt;
  logic [2:0] lat_cnt;
  logic       force_dma;
  logic       arb_now;
  logic       dma_wins;

  assign arb_now  = (state == IDLE) && (cpu_req || dma_req);
  assign dma_wins = dma_req && (force_dma || !cpu_req);
  // Gated by rst so every output reads 0 while reset is asserted.
  assign stallM   = rst & cpu_req & ~cpu_done;

`ifdef DMEM_ARB_STARVE_GUARD_EN
  dmem_arb_starve_guard #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve_guard (
    .clk        (clk),
    .rst        (rst),
    .dma_lost   (arb_now && dma_req && !dma_wins),
    .dma_granted(arb_now && dma_wins),
    .force_dma  (force_dma)
  );
`else
  logic unused_starve_limit;
  assign unused_starve_limit = (STARVE_LIMIT != 0);
  assign force_dma           = 1'b0;
`endif

  // The mem_* registers double as the latched request; they only hold it
  // for the single ISSUE cycle and read 0 otherwise.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      gnt        <= GNT_CPU;
      lat_cnt    <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_funct3 <= '0;
      cpu_done   <= 1'b0;
      dma_done   <= 1'b0;
      cpu_rdata  <= '0;
      dma_rdata  <= '0;
    end else begin
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_funct3 <= '0;
      cpu_done   <= 1'b0;
      dma_done   <= 1'b0;
      case (state)
        IDLE: begin
          if (arb_now) begin
            state  <= ISSUE;
            mem_en <= 1'b1;
            if (dma_wins) begin
              gnt        <= GNT_DMA;
              mem_we     <= dma_we;
              mem_addr   <= dma_addr;
              mem_wdata  <= dma_wdata;
              mem_funct3 <= DMA_FUNCT3;
            end else begin
              gnt        <= GNT_CPU;
              mem_we     <= cpu_we;
              mem_addr   <= cpu_addr;
              mem_wdata  <= cpu_wdata;
              mem_funct3 <= cpu_funct3;
            end
          end
        end
        ISSUE: begin
          if (mem_we) begin
            state    <= DONE;
            cpu_done <= (gnt == GNT_CPU);
            dma_done <= (gnt == GNT_DMA);
          end else begin
            lat_cnt <= 3'(MEM_LATENCY);
            state   <= WAIT;
          end
        end
        WAIT: begin
          lat_cnt <= lat_cnt - 3'd1;
          if (lat_cnt == 3'd1) begin
            if (gnt == GNT_DMA) dma_rdata <= mem_rdata;
            else                cpu_rdata <= mem_rdata;
            cpu_done <= (gnt == GNT_CPU);
            dma_done <= (gnt == GNT_DMA);
            state    <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_dmem_arbiter : randomized and directed checks against a transaction model.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_dmem_arbiter;

  localparam int LAT = 2;
  localparam int SL  = 2;
`ifdef DMEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata, mem_rdata;
  logic [2:0]  cpu_funct3;
  logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata;
  logic        cpu_done, dma_done, stallM, mem_en, mem_we;
  logic [2:0]  mem_funct3;

  always #5 clk = ~clk;

  dmem_arbiter #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_LATENCY(LAT), .STARVE_LIMIT(SL)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_funct3(cpu_funct3), .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .stallM(stallM),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_done(dma_done),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_funct3(mem_funct3), .mem_rdata(mem_rdata)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Transaction-level model: one outstanding access with predicted cycles.
  bit          pend = 1'b0;
  int          p_issue, p_done;
  bit          p_dma, p_we;
  logic [31:0] p_addr, p_wdata, p_rd;
  logic [2:0]  p_f3;
  logic [31:0] m_cpu_rdata = '0, m_dma_rdata = '0;
  int          losses = 0;
  bit          e_cpu_done = 1'b0, e_dma_done = 1'b0;
  bit          prev_cpu_done, prev_dma_done;
  bit          keep_cpu = 1'b0, keep_dma = 1'b0;
  bit          use_next_rd = 1'b0;
  logic [31:0] next_rd;

  int last_cpu_done_cyc = -1, last_dma_done_cyc = -1, cpu_done_cnt = 0;
  int en_log[$];
  bit dut_grants[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  task automatic cycle();
    bit en;
    logic [31:0] e_rd_cpu, e_rd_dma;
    @(posedge clk);
    #1;
    cyc++;
    prev_cpu_done = e_cpu_done;
    prev_dma_done = e_dma_done;
    en         = pend && (cyc == p_issue);
    e_cpu_done = pend && (cyc == p_done) && !p_dma;
    e_dma_done = pend && (cyc == p_done) && p_dma;
    e_rd_cpu   = (e_cpu_done && !p_we) ? p_rd : m_cpu_rdata;
    e_rd_dma   = (e_dma_done && !p_we) ? p_rd : m_dma_rdata;
    check_eq("mem_en",     mem_en,     en);
    check_eq("mem_we",     mem_we,     en && p_we);
    check_eq("mem_addr",   mem_addr,   en ? p_addr : 32'h0);
    check_eq("mem_wdata",  mem_wdata,  en ? p_wdata : 32'h0);
    check_eq("mem_funct3", mem_funct3, en ? p_f3 : 3'h0);
    check_eq("cpu_done",   cpu_done,   e_cpu_done);
    check_eq("dma_done",   dma_done,   e_dma_done);
    check_eq("cpu_rdata",  cpu_rdata,  e_rd_cpu);
    check_eq("dma_rdata",  dma_rdata,  e_rd_dma);
    if (mem_en) en_log.push_back(cyc);
    if (cpu_done) begin last_cpu_done_cyc = cyc; cpu_done_cnt++; dut_grants.push_back(1'b0); end
    if (dma_done) begin last_dma_done_cyc = cyc; dut_grants.push_back(1'b1); end
  endtask

  task automatic model_step();
    bit dw;
    mem_rdata = (pend && !p_we && (cyc == p_issue + LAT)) ? p_rd : $urandom;
    #1;
    check_eq("stallM", stallM, rst && cpu_req && !e_cpu_done);
    if (!rst) begin
      pend = 1'b0; m_cpu_rdata = '0; m_dma_rdata = '0; losses = 0;
      e_cpu_done = 1'b0; e_dma_done = 1'b0;
    end else if (pend && (cyc == p_done)) begin
      if (!p_we) begin
        if (p_dma) m_dma_rdata = p_rd;
        else       m_cpu_rdata = p_rd;
      end
      pend = 1'b0;
    end else if (!pend && (cpu_req || dma_req)) begin
      dw = dma_req && (!cpu_req || (GUARD && losses == SL));
      if (dw) losses = 0;
      else if (dma_req && losses < SL) losses++;
      pend    = 1'b1;
      p_dma   = dw;
      p_issue = cyc + 1;
      p_we    = dw ? dma_we : cpu_we;
      p_addr  = dw ? dma_addr : cpu_addr;
      p_wdata = dw ? dma_wdata : cpu_wdata;
      p_f3    = dw ? 3'b010 : cpu_funct3;
      p_done  = cyc + 2 + (p_we ? 0 : LAT);
      p_rd    = use_next_rd ? next_rd : $urandom;
      use_next_rd = 1'b0;
    end
  endtask

  task automatic cpu_issue(input bit we, input logic [31:0] a, input logic [31:0] d,
                           input logic [2:0] f);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_funct3 = f;
  endtask

  task automatic dma_issue(input bit we, input logic [31:0] a, input logic [31:0] d);
    dma_req = 1'b1; dma_we = we; dma_addr = a; dma_wdata = d;
  endtask

  task automatic drive_hold();
    if (prev_cpu_done && !keep_cpu) cpu_req = 1'b0;
    if (prev_dma_done && !keep_dma) dma_req = 1'b0;
  endtask

  task automatic drive_random();
    if (prev_cpu_done) cpu_req = ($urandom_range(7) == 0);
    else if (!cpu_req && $urandom_range(2) == 0)
      cpu_issue(1'($urandom_range(1)), $urandom, $urandom, 3'($urandom_range(7)));
    if (prev_dma_done) dma_req = ($urandom_range(7) == 0);
    else if (!dma_req && $urandom_range(2) == 0)
      dma_issue(1'($urandom_range(1)), $urandom, $urandom);
  endtask

  task automatic run_until_idle();
    for (int i = 0; i < 60 && (pend || cpu_req || dma_req); i++) begin
      cycle(); drive_hold(); model_step();
    end
  endtask

  task automatic apply_reset();
    cycle(); rst = 1'b0; cpu_req = 1'b0; dma_req = 1'b0; model_step();
    cycle(); rst = 1'b1; model_step();
  endtask

  initial begin
    int t0, cnt0;
    rst = 1'b0; cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0; cpu_funct3 = 0;
    dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0; mem_rdata = 0;
    for (int i = 0; i < 4; i++) begin
      cycle(); rst = (i >= 2); model_step();
    end

    // CPU load with a known memory word
    cycle(); next_rd = 32'hDEADBEEF; use_next_rd = 1'b1;
    cpu_issue(1'b0, 32'h10, 32'h0, 3'b010); t0 = cyc; model_step();
    run_until_idle();
    check_eq("load_done_cycle", last_cpu_done_cyc - t0, 2 + LAT);
    check_eq("load_rdata", cpu_rdata, 32'hDEADBEEF);

    // DMA store
    cycle(); dma_issue(1'b1, 32'h40, 32'h12345678); t0 = cyc; model_step();
    run_until_idle();
    check_eq("store_done_cycle", last_dma_done_cyc - t0, 2);

    // Simultaneous requests: CPU read first, then DMA write
    dut_grants.delete(); en_log.delete();
    cycle(); cpu_issue(1'b0, 32'h80, 32'h0, 3'b000); dma_issue(1'b1, 32'h84, 32'hA5A5A5A5);
    model_step();
    run_until_idle();
    check_eq("both_grant_count", dut_grants.size(), 2);
    check_eq("both_first_cpu", (dut_grants.size() > 0) ? dut_grants[0] : 1'b1, 1'b0);
    check_eq("both_second_dma", (dut_grants.size() > 1) ? dut_grants[1] : 1'b0, 1'b1);
    check_eq("both_issue_gap", (en_log.size() > 1) ? en_log[1] - en_log[0] : 0, LAT + 3);

    // Reset during the wait of a CPU read
    cycle(); cpu_issue(1'b0, 32'h20, 32'h0, 3'b010); t0 = cyc; model_step();
    cycle(); drive_hold(); model_step();
    cycle(); rst = 1'b0; cpu_req = 1'b0; model_step();
    cycle(); rst = 1'b1; model_step();
    for (int i = 0; i < 4; i++) begin cycle(); model_step(); end
    check_eq("abort_no_done", last_cpu_done_cyc > t0, 1'b0);
    cycle(); cpu_issue(1'b0, 32'h24, 32'h0, 3'b010); t0 = cyc; model_step();
    run_until_idle();
    check_eq("post_reset_latency", last_cpu_done_cyc - t0, 2 + LAT);

    // Request held one cycle past done is a second access
    en_log.delete(); cnt0 = cpu_done_cnt; keep_cpu = 1'b1;
    cycle(); cpu_issue(1'b1, 32'h30, 32'h55AA55AA, 3'b010); model_step();
    for (int i = 0; i < 20 && keep_cpu; i++) begin
      cycle(); drive_hold();
      if (prev_cpu_done) keep_cpu = 1'b0;
      model_step();
    end
    run_until_idle();
    check_eq("hold_issue_count", en_log.size(), 2);
    check_eq("hold_done_count", cpu_done_cnt - cnt0, 2);

    // Continuous contention: grant order depends on the starvation guard
    apply_reset();
    dut_grants.delete(); keep_cpu = 1'b1; keep_dma = 1'b1;
    cycle(); cpu_issue(1'b1, 32'h100, 32'h1, 3'b010); dma_issue(1'b1, 32'h200, 32'h2);
    model_step();
    for (int i = 0; i < 80 && dut_grants.size() < 6; i++) begin
      cycle(); drive_hold(); model_step();
    end
    keep_cpu = 1'b0; keep_dma = 1'b0;
    cycle(); cpu_req = 1'b0; dma_req = 1'b0; model_step();
    run_until_idle();
    check_eq("guard_grant_count", dut_grants.size() >= 6, 1'b1);
    for (int i = 0; i < 6; i++)
      check_eq($sformatf("guard_grant_%0d", i),
               (i < dut_grants.size()) ? 2'(dut_grants[i]) : 2'd3,
               2'(GUARD && (i % 3 == 2)));

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cycle(); drive_random(); model_step();
    end
    cycle(); cpu_req = 1'b0; dma_req = 1'b0; model_step();
    run_until_idle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
